// File: rtl/rnbip_ctrl_pkg.sv
// Shared definitions for the RNBIP control sequencer: state encoding,
// opcode classes, jump condition codes and the condition evaluator.
package rnbip_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_F_ADDR = 3'd1,
        ST_F_READ = 3'd2,
        ST_DECODE = 3'd3,
        ST_O_ADDR = 3'd4,
        ST_O_READ = 3'd5,
        ST_EXEC   = 3'd6,
        ST_HALT   = 3'd7
    } state_t;

    localparam logic [1:0] CLS_ALU  = 2'b00;
    localparam logic [1:0] CLS_ALUI = 2'b01;
    localparam logic [1:0] CLS_JMP  = 2'b10;
    localparam logic [1:0] CLS_SYS  = 2'b11;

    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_Z      = 2'b01;
    localparam logic [1:0] COND_C      = 2'b10;
    localparam logic [1:0] COND_NZ     = 2'b11;

    localparam logic [7:0] OP_HALT = 8'hFF;

    function automatic logic cond_eval(input logic [1:0] cc, input logic z, input logic c);
        logic res;
        case (cc)
            COND_ALWAYS: res = 1'b1;
            COND_Z:      res = z;
            COND_C:      res = c;
            COND_NZ:     res = ~z;
            default:     res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rnbip_sequencer_if.sv
// Control bundle between the RNBIP sequencer (master) and the datapath (slave).
interface rnbip_sequencer_if #(
    parameter int OPW  = 8,
    parameter int AOPW = 4
);
    logic            RUN;
    logic            MEM_RDY;
    logic [OPW-1:0]  IR_IN;
    logic            Z;
    logic            C;
    logic            E_PC;
    logic            L_MAR;
    logic            E_MEM;
    logic            L_IR;
    logic            L_OR;
    logic            INC_PC;
    logic            L_PC;
    logic            E_OR;
    logic            E_ALU;
    logic            L_ACC;
    logic            L_FLAGS;
    logic            ALU_SRC_OR;
    logic [AOPW-1:0] ALU_OP;
    logic            HALTED;
    logic [2:0]      STATE;

    modport master (
        input  RUN, MEM_RDY, IR_IN, Z, C,
        output E_PC, L_MAR, E_MEM, L_IR, L_OR, INC_PC, L_PC, E_OR,
               E_ALU, L_ACC, L_FLAGS, ALU_SRC_OR, ALU_OP, HALTED, STATE
    );

    modport slave (
        output RUN, MEM_RDY, IR_IN, Z, C,
        input  E_PC, L_MAR, E_MEM, L_IR, L_OR, INC_PC, L_PC, E_OR,
               E_ALU, L_ACC, L_FLAGS, ALU_SRC_OR, ALU_OP, HALTED, STATE
    );
endinterface

// File: rtl/rnbip_decoder.sv
// Combinational opcode decoder: class, operand need, halt detect, ALU
// function and jump condition outcome from the live flags.
module rnbip_decoder
    import rnbip_ctrl_pkg::*;
#(
    parameter int OPW  = 8,
    parameter int AOPW = 4
) (
    input  logic [OPW-1:0]  ir,
    input  logic            z,
    input  logic            c,
    output logic [1:0]      cls,
    output logic            needs_operand,
    output logic            is_halt,
    output logic [AOPW-1:0] alu_op,
    output logic            cond_true
);

    assign cls           = ir[OPW-1 -: 2];
    assign needs_operand = (cls == CLS_ALUI) || (cls == CLS_JMP);
    assign is_halt       = (ir == OP_HALT);
    assign alu_op        = ir[AOPW-1:0];
    assign cond_true     = cond_eval(ir[1:0], z, c);

endmodule

// File: rtl/rnbip_sequencer.sv
// Fetch/decode/execute sequencer for the RNBIP datapath; sole owner of all
// bus-enable strobes, so at most one E_* is driven in any cycle.
module rnbip_sequencer
    import rnbip_ctrl_pkg::*;
#(
    parameter int OPW  = 8,
    parameter int AOPW = 4
) (
    input  logic               CLK,
    input  logic               RSTn,
    rnbip_sequencer_if.master  bus
);

    state_t          state_r;
    state_t          state_next_s;
    logic [1:0]      cls_s;
    logic            needs_operand_s;
    logic            is_halt_s;
    logic [AOPW-1:0] dec_alu_op_s;
    logic            cond_true_s;

    logic            e_pc_s, l_mar_s, e_mem_s, l_ir_s, l_or_s, inc_pc_s, l_pc_s;
    logic            e_or_s, e_alu_s, l_acc_s, l_flags_s, alu_src_or_s, halted_s;
    logic [AOPW-1:0] alu_op_s;

    rnbip_decoder #(.OPW(OPW), .AOPW(AOPW)) u_decoder (
        .ir            (bus.IR_IN),
        .z             (bus.Z),
        .c             (bus.C),
        .cls           (cls_s),
        .needs_operand (needs_operand_s),
        .is_halt       (is_halt_s),
        .alu_op        (dec_alu_op_s),
        .cond_true     (cond_true_s)
    );

    // State register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:   state_next_s = bus.RUN ? ST_F_ADDR : ST_IDLE;
            ST_F_ADDR: state_next_s = ST_F_READ;
            ST_F_READ: state_next_s = bus.MEM_RDY ? ST_DECODE : ST_F_READ;
            ST_DECODE: begin
                if (needs_operand_s) begin
                    state_next_s = ST_O_ADDR;
                end else if (cls_s == CLS_ALU) begin
                    state_next_s = ST_EXEC;
                end else if (is_halt_s) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_F_ADDR;
                end
            end
            ST_O_ADDR: state_next_s = ST_O_READ;
            ST_O_READ: state_next_s = bus.MEM_RDY ? ST_EXEC : ST_O_READ;
            ST_EXEC:   state_next_s = ST_F_ADDR;
            ST_HALT:   state_next_s = ST_HALT;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Strobe decode; reads hold E_MEM while loads/increment wait for MEM_RDY
    always_comb begin
        e_pc_s = 1'b0; l_mar_s = 1'b0; e_mem_s = 1'b0; l_ir_s = 1'b0;
        l_or_s = 1'b0; inc_pc_s = 1'b0; l_pc_s = 1'b0; e_or_s = 1'b0;
        e_alu_s = 1'b0; l_acc_s = 1'b0; l_flags_s = 1'b0; alu_src_or_s = 1'b0;
        halted_s = 1'b0; alu_op_s = '0;
        case (state_r)
            ST_F_ADDR, ST_O_ADDR: begin
                e_pc_s  = 1'b1;
                l_mar_s = 1'b1;
            end
            ST_F_READ: begin
                e_mem_s  = 1'b1;
                l_ir_s   = bus.MEM_RDY;
                inc_pc_s = bus.MEM_RDY;
            end
            ST_O_READ: begin
                e_mem_s  = 1'b1;
                l_or_s   = bus.MEM_RDY;
                inc_pc_s = bus.MEM_RDY;
            end
            ST_EXEC: begin
                alu_op_s = dec_alu_op_s;
                case (cls_s)
                    CLS_ALU, CLS_ALUI: begin
                        e_alu_s      = 1'b1;
                        l_acc_s      = 1'b1;
                        l_flags_s    = 1'b1;
                        alu_src_or_s = (cls_s == CLS_ALUI);
                    end
                    CLS_JMP: begin
                        if (cond_true_s) begin
                            e_or_s = 1'b1;
                            l_pc_s = 1'b1;
                        end else begin
                            e_or_s = 1'b0;
                            l_pc_s = 1'b0;
                        end
                    end
                    default: begin
                        e_alu_s = 1'b0;
                    end
                endcase
            end
            ST_HALT: halted_s = 1'b1;
            default: halted_s = 1'b0;
        endcase
    end

    assign bus.E_PC       = e_pc_s;
    assign bus.L_MAR      = l_mar_s;
    assign bus.E_MEM      = e_mem_s;
    assign bus.L_IR       = l_ir_s;
    assign bus.L_OR       = l_or_s;
    assign bus.INC_PC     = inc_pc_s;
    assign bus.L_PC       = l_pc_s;
    assign bus.E_OR       = e_or_s;
    assign bus.E_ALU      = e_alu_s;
    assign bus.L_ACC      = l_acc_s;
    assign bus.L_FLAGS    = l_flags_s;
    assign bus.ALU_SRC_OR = alu_src_or_s;
    assign bus.ALU_OP     = alu_op_s;
    assign bus.HALTED     = halted_s;
    assign bus.STATE      = state_r;

endmodule
